// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle target for the MEM-stage load/store port.
// Captures one request, waits LATENCY cycles, performs a big-endian byte/half/word
// access to a word-organised RAM, then pulses resp_valid for one cycle.
// Stall holds the pipeline while a request is outstanding.
// Optional build macro DMEM_ACCESS_COUNTERS_EN adds load_count/store_count outputs.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        Stall,
`ifdef DMEM_ACCESS_COUNTERS_EN
    output logic [31:0] load_count,
    output logic [31:0] store_count,
`endif
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            w_capture;
    logic            w_access;

    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic [AW-1:0]   w_index;
    logic [1:0]      w_lane;
    logic            w_misaligned;
    logic [31:0]     w_old_word;
    logic [31:0]     w_new_word;
    logic [7:0]      w_lane_byte;
    logic [15:0]     w_lane_half;
    logic [31:0]     w_load;
    logic            w_mem_we;

    // Address bits above the word index are ignored so accesses wrap.
    logic            w_unused_addr;
    assign w_unused_addr = ^req_addr[31:AW+2];

    // State register; synchronous reset returns to idle from any state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; w_access marks the edge on which the RAM is touched.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_index    = r_addr[AW+1:2];
    assign w_lane     = r_addr[1:0];
    assign w_old_word = r_mem[w_index];

    // Size 11 behaves as a word; halves need addr[0]=0, words need addr[1:0]=0.
    assign w_misaligned = (r_size[1] && (w_lane != 2'b00)) ||
                          ((r_size == 2'b01) && w_lane[0]);

    // Load path: pick the big-endian lane, right-justify, then extend.
    always_comb begin
        w_lane_byte = 8'h00;
        w_lane_half = 16'h0000;
        w_load      = w_old_word;
        case (w_lane)
            2'd0:    w_lane_byte = w_old_word[31:24];
            2'd1:    w_lane_byte = w_old_word[23:16];
            2'd2:    w_lane_byte = w_old_word[15:8];
            default: w_lane_byte = w_old_word[7:0];
        endcase
        w_lane_half = w_lane[1] ? w_old_word[15:0] : w_old_word[31:16];
        if (r_size == 2'b00) begin
            w_load = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
        end else if (r_size == 2'b01) begin
            w_load = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
        end else begin
            w_load = w_old_word;
        end
    end

    // Store path: read-modify-write so only the addressed lanes change.
    always_comb begin
        w_new_word = w_old_word;
        if (r_size == 2'b00) begin
            case (w_lane)
                2'd0:    w_new_word[31:24] = r_wdata[7:0];
                2'd1:    w_new_word[23:16] = r_wdata[7:0];
                2'd2:    w_new_word[15:8]  = r_wdata[7:0];
                default: w_new_word[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_size == 2'b01) begin
            if (w_lane[1]) begin
                w_new_word[15:0] = r_wdata[15:0];
            end else begin
                w_new_word[31:16] = r_wdata[15:0];
            end
        end else begin
            w_new_word = r_wdata;
        end
    end

    // Reset on the access edge wins, so a pending store is dropped.
    assign w_mem_we = w_access & ~Reset & r_write & ~w_misaligned;

    // RAM write port; contents survive Reset.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_index] <= w_new_word;
        end
    end

    // Request capture, latency countdown and registered response.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt    <= CW'(LATENCY - 1);
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr[AW+1:0];
                r_wdata  <= req_wdata;
            end else if ((r_state == StWait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_rdata <= (r_write || w_misaligned) ? 32'h0 : w_load;
                r_err   <= w_misaligned;
            end
        end
    end

`ifdef DMEM_ACCESS_COUNTERS_EN
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    // Count completed non-error accesses on the edge entering RESP.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_load_count  <= 32'h0;
            r_store_count <= 32'h0;
        end else if (w_access && !w_misaligned) begin
            if (r_write) begin
                r_store_count <= r_store_count + 32'd1;
            end else begin
                r_load_count <= r_load_count + 32'd1;
            end
        end
    end

    assign load_count  = r_load_count;
    assign store_count = r_store_count;
`else
    // Access counters not built in this configuration.
`endif

    assign resp_valid = (r_state == StResp);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign busy       = (r_state != StIdle);
    assign Stall      = req_valid & ~resp_valid;

endmodule
